uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per frame (range 1..255).
REQ-002 SHALL have parameter SOF_BYTE, default 8'hA5, meaning the start-of-frame marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the inter-byte timeout in clk cycles (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 SHALL have ports s_valid (input, 1) and s_data (input, 8): a received byte from the UART receiver, one-cycle pulse, no backpressure.
REQ-007 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, 8) and m_last (output, 1): the verified payload stream.
REQ-008 SHALL have ports frame_ok (output, 1) and frame_err (output, 1): one-cycle status pulses.
REQ-009 SHALL have port err_code, output, 2 bits: 1 = bad length, 2 = bad checksum, 3 = timeout; valid while frame_err=1.
REQ-010 SHALL have port overrun, output, 1 bit: a one-cycle pulse when an input byte is dropped.

Function
REQ-011 The frame format SHALL be SOF_BYTE, LEN, LEN payload bytes, then CSUM, where CSUM = LEN XOR every payload byte.
REQ-012 The FSM SHALL have the states IDLE, LEN, PAYLOAD, CSUM and DRAIN.
REQ-013 IDLE SHALL discard every byte other than SOF_BYTE; on SOF_BYTE it SHALL go to LEN.
REQ-014 In LEN, if LEN==0 or LEN>MAX_LEN, the block SHALL pulse frame_err with err_code=1 and go to IDLE; otherwise it SHALL store LEN, seed the running XOR with LEN and go to PAYLOAD.
REQ-015 In PAYLOAD, the block SHALL write each byte into the buffer at an index counting from 0 and fold it into the XOR; after byte LEN-1 it SHALL go to CSUM.
REQ-016 In CSUM, on a match the block SHALL pulse frame_ok and go to DRAIN; on a mismatch it SHALL pulse frame_err with err_code=2 and go to IDLE with the buffer discarded.
REQ-017 m_valid SHALL rise on the first cycle after the CSUM byte is accepted (latency 1).
REQ-018 A beat SHALL transfer when m_valid && m_ready.
REQ-019 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-020 m_last SHALL be 1 only on buffer index LEN-1; the transfer of that beat SHALL return the FSM to IDLE in the next cycle.
REQ-021 An s_valid byte arriving in DRAIN SHALL be dropped and SHALL pulse overrun; the parser SHALL not resynchronise on it.
REQ-022 A SOF_BYTE seen in PAYLOAD or CSUM SHALL be treated as data, with no resync.
REQ-023 frame_ok, frame_err and overrun SHALL never assert in the same cycle, except overrun together with the DRAIN-exit beat.
REQ-024 Counters SHALL be $clog2(MAX_LEN+1) bits wide, and the buffer index SHALL never exceed MAX_LEN-1.

Reset
REQ-025 rst SHALL force the FSM to IDLE and clear the counters and XOR; m_valid, m_last, frame_ok, frame_err and overrun SHALL be 0, err_code 0 and m_data 8'h00.
REQ-026 A reset asserted mid-frame or mid-drain SHALL abandon the frame with no status pulse; buffer contents are don't-care.

Configuration
REQ-027 With UART_PARSER_TIMEOUT_EN defined, an idle counter SHALL reset on each s_valid in LEN, PAYLOAD or CSUM; on reaching TIMEOUT_CYCLES it SHALL pulse frame_err with err_code=3 and go to IDLE. It SHALL not run in IDLE or DRAIN.
REQ-028 Without UART_PARSER_TIMEOUT_EN, no timeout counter SHALL exist, err_code SHALL never be 3, and the TIMEOUT_CYCLES parameter SHALL be ignored.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the err_code typedef and constants ERR_LEN, ERR_CSUM and ERR_TIMEOUT.
REQ-030 The payload buffer SHALL be the sub-module uart_frame_buf: MAX_LEN x 8, one synchronous write port and one read port with registered output, and no reset on its storage.

Verification
REQ-031 Frame A5 03 11 22 33 03 with m_ready=1 SHALL yield beats 11, 22, 33 with m_last on 33 and exactly one frame_ok.
REQ-032 Frame A5 02 AA BB 00 (the correct CSUM is 13) SHALL give frame_err with err_code=2 and no m_valid.
REQ-033 Bytes A5 00 and, separately, A5 11 with MAX_LEN=16 SHALL each give frame_err with err_code=1.
REQ-034 A valid 4-byte frame with m_ready held low SHALL keep m_valid=1 and m_data stable; a byte 55 sent meanwhile SHALL give overrun=1; after m_ready is raised all 4 beats SHALL arrive.
REQ-035 With UART_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=64, sending A5 04 11 then going silent SHALL give frame_err with err_code=3 64 cycles after the byte 11; a following valid frame SHALL parse OK.
REQ-036 rst pulsed mid-payload and then a valid frame A5 01 7E 7F SHALL give no status until the new frame, then beat 7E with m_last and frame_ok.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
// The checksum fold helper is shared by the parser and its users.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_LEN     = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 storage without reset, one synchronous write port
// and one read port whose output register holds until the next read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read output register; holding it while rd_en is low keeps m_data stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 8'h00;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: SOF, LEN, payload, XOR checksum; verified payload is
// replayed on a valid/ready stream. Optional inter-byte timeout: UART_PARSER_TIMEOUT_EN.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int         CW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_len, w_len_nxt;
  logic [CW-1:0]   r_wr_idx, w_wr_idx_nxt;
  logic [CW-1:0]   r_rd_idx, w_rd_idx_nxt;
  logic [7:0]      r_xor, w_xor_nxt;
  logic            r_m_valid, w_m_valid_nxt;
  logic            r_m_last, w_m_last_nxt;
  logic            r_frame_ok, w_frame_ok_nxt;
  logic            r_frame_err, w_frame_err_nxt;
  err_code_t       r_err_code, w_err_code_nxt;
  logic            r_overrun, w_overrun_nxt;
  logic            w_wr_en, w_rd_en, w_timeout;
  logic [7:0]      w_rd_data;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_idle_cnt;
  logic            w_active;

  assign w_active  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  assign w_timeout = w_active && !s_valid && (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, only running while a frame is being received
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (!w_active || s_valid || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and status decode
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_wr_idx_nxt    = r_wr_idx;
    w_rd_idx_nxt    = r_rd_idx;
    w_xor_nxt       = r_xor;
    w_m_valid_nxt   = r_m_valid;
    w_m_last_nxt    = r_m_last;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_err_code_nxt  = ERR_NONE;
    w_overrun_nxt   = 1'b0;
    w_wr_en         = 1'b0;
    w_rd_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid && (s_data == SOF_BYTE)) begin
          w_state_nxt = ST_LEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (s_valid) begin
          if ((s_data == 8'd0) || (s_data > MAX_LEN_B)) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_LEN;
            w_state_nxt     = ST_IDLE;
          end else begin
            w_len_nxt    = s_data[CW-1:0];
            w_xor_nxt    = s_data;
            w_wr_idx_nxt = '0;
            w_state_nxt  = ST_PAYLOAD;
          end
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TIMEOUT;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (s_valid) begin
          w_wr_en      = 1'b1;
          w_xor_nxt    = csum_fold(r_xor, s_data);
          w_wr_idx_nxt = r_wr_idx + ONE;
          if (r_wr_idx == (r_len - ONE)) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TIMEOUT;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (s_valid) begin
          if (s_data == r_xor) begin
            // Prefetch index 0 so the first beat is presented one cycle later
            w_frame_ok_nxt = 1'b1;
            w_rd_en        = 1'b1;
            w_rd_idx_nxt   = '0;
            w_m_valid_nxt  = 1'b1;
            w_m_last_nxt   = (r_len == ONE);
            w_state_nxt    = ST_DRAIN;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_CSUM;
            w_state_nxt     = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TIMEOUT;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
      ST_DRAIN: begin
        w_overrun_nxt = s_valid;
        if (r_m_valid && m_ready) begin
          if (r_m_last) begin
            w_m_valid_nxt = 1'b0;
            w_m_last_nxt  = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_rd_en       = 1'b1;
            w_rd_idx_nxt  = r_rd_idx + ONE;
            w_m_last_nxt  = ((r_rd_idx + ONE) == (r_len - ONE));
            w_state_nxt   = ST_DRAIN;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_m_valid_nxt = 1'b0;
        w_m_last_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_xor       <= 8'h00;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_overrun   <= 1'b0;
    end else begin
      r_len       <= w_len_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_xor       <= w_xor_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_last    <= w_m_last_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_idx[AW-1:0]),
    .wr_data (s_data),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_idx_nxt[AW-1:0]),
    .rd_data (w_rd_data)
  );

  assign m_valid   = r_m_valid;
  assign m_data    = w_rd_data;
  assign m_last    = r_m_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus queues expected beats and
// status pulses, a negedge monitor pops and compares them as the DUT emits.
module tb_uart_frame_parser;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] kind;   // 0 ok, 1 err, 2 overrun
    logic [1:0] code;
  } stat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  beat_t      exp_beats[$];
  stat_t      exp_stats[$];
  logic [7:0] tx_q[$];

  uart_frame_parser #(
    .MAX_LEN        (16),
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: compares every emitted beat and status pulse against the queues
  beat_t      mon_beat;
  stat_t      mon_stat;
  logic [1:0] act_kind;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_beats.size() == 0) begin
          n_errors++;
          $display("FAIL beat_unexpected: got data=%02h last=%0b, required no beat", m_data, m_last);
        end else begin
          mon_beat = exp_beats.pop_front();
          if (m_data !== mon_beat.data || m_last !== mon_beat.last) begin
            n_errors++;
            $display("FAIL beat: got data=%02h last=%0b, required data=%02h last=%0b",
                     m_data, m_last, mon_beat.data, mon_beat.last);
          end
        end
      end
      if (stall_prev && m_valid) begin
        n_checks++;
        if (m_data !== prev_data || m_last !== prev_last) begin
          n_errors++;
          $display("FAIL stall_stable: got data=%02h last=%0b, required data=%02h last=%0b",
                   m_data, m_last, prev_data, prev_last);
        end
      end
      if (frame_ok || frame_err || overrun) begin
        n_checks++;
        act_kind = frame_ok ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
        if ((32'(frame_ok) + 32'(frame_err) + 32'(overrun)) > 1) begin
          n_errors++;
          $display("FAIL status_exclusive: got ok=%0b err=%0b ovr=%0b, required one at a time",
                   frame_ok, frame_err, overrun);
        end else if (exp_stats.size() == 0) begin
          n_errors++;
          $display("FAIL status_unexpected: got kind=%0d code=%0d, required no status", act_kind, err_code);
        end else begin
          mon_stat = exp_stats.pop_front();
          if (act_kind !== mon_stat.kind || (frame_err && err_code !== mon_stat.code)) begin
            n_errors++;
            $display("FAIL status: got kind=%0d code=%0d, required kind=%0d code=%0d",
                     act_kind, err_code, mon_stat.kind, mon_stat.code);
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l);
    exp_beats.push_back('{data: d, last: l});
  endtask

  task automatic exp_stat(input logic [1:0] k, input logic [1:0] c);
    exp_stats.push_back('{kind: k, code: c});
  endtask

  // Sends tx_q back to back, one byte per cycle; returns at posedge+1
  task automatic send_tx();
    foreach (tx_q[i]) begin
      s_valid = 1'b1;
      s_data  = tx_q[i];
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_stats.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    n_checks++;
    if (exp_beats.size() != 0 || exp_stats.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d beats and %0d status pending, required 0",
               exp_beats.size(), exp_stats.size());
      exp_beats.delete();
      exp_stats.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid",   {7'd0, m_valid},   8'h00);
    check("rst_m_last",    {7'd0, m_last},    8'h00);
    check("rst_frame_ok",  {7'd0, frame_ok},  8'h00);
    check("rst_frame_err", {7'd0, frame_err}, 8'h00);
    check("rst_overrun",   {7'd0, overrun},   8'h00);
    check("rst_err_code",  {6'd0, err_code},  8'h00);
    check("rst_m_data",    m_data,            8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic 3-byte frame
    exp_beat(8'h11, 1'b0); exp_beat(8'h22, 1'b0); exp_beat(8'h33, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_tx();
    wait_done(50, 1'b0);

    // Bad checksum: correct value would be 13
    exp_stat(2'd1, 2'd2);
    tx_q = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_tx();
    wait_done(50, 1'b0);

    // Zero length and length over MAX_LEN
    exp_stat(2'd1, 2'd1);
    tx_q = {8'hA5, 8'h00};
    send_tx();
    wait_done(50, 1'b0);
    exp_stat(2'd1, 2'd1);
    tx_q = {8'hA5, 8'h11};
    send_tx();
    wait_done(50, 1'b0);

    // Garbage in IDLE is ignored, then SOF bytes inside the payload are data
    exp_beat(8'hA5, 1'b0); exp_beat(8'hA5, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'h00, 8'hFF, 8'h33, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
    send_tx();
    wait_done(50, 1'b0);

    // Backpressure with an overrun byte while draining
    m_ready = 1'b0;
    exp_beat(8'h10, 1'b0); exp_beat(8'h20, 1'b0); exp_beat(8'h30, 1'b0); exp_beat(8'h40, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
    send_tx();
    repeat (3) @(posedge clk);
    #1;
    check("stall_m_valid", {7'd0, m_valid}, 8'h01);
    check("stall_m_data",  m_data,          8'h10);
    exp_stat(2'd2, 2'd0);
    tx_q = {8'h55};
    send_tx();
    repeat (3) @(posedge clk);
    #1;
    check("stall_m_valid2", {7'd0, m_valid}, 8'h01);
    check("stall_m_data2",  m_data,          8'h10);
    m_ready = 1'b1;
    wait_done(50, 1'b0);

    // Full-length frame (bytes 00..0F, checksum 10) with random backpressure
    tx_q = {8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i));
      exp_beat(8'(i), (i == 15));
    end
    tx_q.push_back(8'h10);
    exp_stat(2'd0, 2'd0);
    send_tx();
    wait_done(200, 1'b1);

    // Single-byte frame: first beat is also last
    exp_beat(8'hC3, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'hA5, 8'h01, 8'hC3, 8'hC2};
    send_tx();
    wait_done(50, 1'b0);

    // Reset mid-payload abandons the frame silently
    tx_q = {8'hA5, 8'h04, 8'h11, 8'h22};
    send_tx();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_beat(8'h7E, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_tx();
    wait_done(50, 1'b0);

`ifdef UART_PARSER_TIMEOUT_EN
    // Silence after byte 11 times out exactly 64 cycles later
    exp_stat(2'd1, 2'd3);
    tx_q = {8'hA5, 8'h04, 8'h11};
    send_tx();
    repeat (63) @(posedge clk);
    #1;
    check("timeout_early", {7'd0, frame_err}, 8'h00);
    @(posedge clk);
    #1;
    check("timeout_err",  {7'd0, frame_err}, 8'h01);
    check("timeout_code", {6'd0, err_code},  8'h03);
    wait_done(50, 1'b0);
    exp_beat(8'h01, 1'b0); exp_beat(8'h02, 1'b1);
    exp_stat(2'd0, 2'd0);
    tx_q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
    send_tx();
    wait_done(50, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
